// File: rtl/alu_frame_interface.sv
`default_nettype none
// ============================================================================
// Module   : alu_frame_interface
// Purpose  : Bridge between 8-bit UART RX/TX FIFOs and a DATA_WIDTH-bit ALU.
//            Collects an A/B/opcode frame byte by byte and presents all operands
//            to the ALU in one update. Waits ALU_LATENCY cycles, then returns
//            the result LSB first, followed by a status byte
//            {seq[5:0], carry, zero}. An idle gap longer than TIMEOUT_CYCLES
//            inside a frame discards the partial frame.
// Ports    : i_clock       - system clock, rising edge
//            i_reset       - asynchronous active-low reset
//            i_rxff_data   - RX FIFO head byte (show-ahead)
//            i_rxff_empty  - RX FIFO empty
//            o_rxff_read   - RX pop strobe (byte consumed this cycle)
//            o_operandA/B  - ALU operands
//            o_opcode      - ALU opcode
//            i_result      - ALU result
//            i_carry       - ALU carry-out
//            i_txff_full   - TX FIFO full
//            o_txff_data   - byte to TX FIFO
//            o_txff_write  - TX push strobe
//            o_frame_error - one-cycle pulse when a partial frame times out
//            o_busy        - a frame is in progress
// Revision : 1.0 - initial release
// ============================================================================
module alu_frame_interface #(
  parameter int DATA_WIDTH     = 8,
  parameter int OPCODE_WIDTH   = 6,
  parameter int ALU_LATENCY    = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [7:0]              i_rxff_data,
  input  logic                    i_rxff_empty,
  output logic                    o_rxff_read,
  output logic [DATA_WIDTH-1:0]   o_operandA,
  output logic [DATA_WIDTH-1:0]   o_operandB,
  output logic [OPCODE_WIDTH-1:0] o_opcode,
  input  logic [DATA_WIDTH-1:0]   i_result,
  input  logic                    i_carry,
  input  logic                    i_txff_full,
  output logic [7:0]              o_txff_data,
  output logic                    o_txff_write,
  output logic                    o_frame_error,
  output logic                    o_busy
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int LAST_IDX = 2 * BYTES;
  localparam int CW       = $clog2(LAST_IDX + 1);
  localparam int TXW      = $clog2(BYTES + 1);
  localparam int SW       = 8 * (BYTES + 1);
  // The timeout counter only needs to reach TIMEOUT_CYCLES-1: the expiring
  // idle cycle itself fires the discard.
  localparam int TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CW-1:0]  OPC_IDX  = CW'(LAST_IDX);
  localparam logic [TXW-1:0] TX_LAST  = TXW'(BYTES);
  localparam logic [3:0]     LAT_LAST = 4'(ALU_LATENCY);
  localparam logic [TW-1:0]  TO_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit             TO_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_RECV = 2'd0,
    S_EXEC = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t                  state;
  logic [CW-1:0]           byte_cnt;
  logic [TW-1:0]           timeout_cnt;
  logic [3:0]              lat_cnt;
  logic [TXW-1:0]          tx_idx;
  logic [5:0]              seq;
  logic [DATA_WIDTH-1:0]   shadow_a;
  logic [DATA_WIDTH-1:0]   shadow_b;
  logic [SW-1:0]           tx_buf;
  logic                    frame_error;
  logic                    busy;
  logic                    accept;
  logic                    tx_fire;

  // Gating with the reset keeps the pop strobe low while reset is held,
  // even though the state register already reads RECV.
  assign accept        = (state == S_RECV) && !i_rxff_empty && i_reset;
  assign tx_fire       = (state == S_SEND) && !i_txff_full;

  assign o_rxff_read   = accept;
  assign o_txff_write  = tx_fire;
  assign o_txff_data   = (state == S_SEND) ? tx_buf[7:0] : 8'd0;
  assign o_frame_error = frame_error;
  assign o_busy        = busy;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state       <= S_RECV;
      byte_cnt    <= '0;
      timeout_cnt <= '0;
      lat_cnt     <= '0;
      tx_idx      <= '0;
      seq         <= '0;
      shadow_a    <= '0;
      shadow_b    <= '0;
      tx_buf      <= '0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
      o_operandA  <= '0;
      o_operandB  <= '0;
      o_opcode    <= '0;
    end else begin
      frame_error <= 1'b0;
      case (state)
        S_RECV: begin
          if (accept) begin
            timeout_cnt <= '0;
            busy        <= 1'b1;
            if (byte_cnt == OPC_IDX) begin
              // Atomic update: the ALU never sees a half-written frame.
              o_operandA <= shadow_a;
              o_operandB <= shadow_b;
              o_opcode   <= i_rxff_data[OPCODE_WIDTH-1:0];
              byte_cnt   <= '0;
              lat_cnt    <= '0;
              state      <= S_EXEC;
            end else begin
              for (int i = 0; i < BYTES; i++) begin
                if (byte_cnt == CW'(i))
                  shadow_a[8*i +: 8] <= i_rxff_data;
                if (byte_cnt == CW'(BYTES + i))
                  shadow_b[8*i +: 8] <= i_rxff_data;
              end
              byte_cnt <= byte_cnt + CW'(1);
            end
          end else if (TO_EN && (byte_cnt != '0)) begin
            // Not accepting in RECV means the RX FIFO is empty: an idle cycle.
            if (timeout_cnt == TO_LAST) begin
              byte_cnt    <= '0;
              timeout_cnt <= '0;
              shadow_a    <= '0;
              shadow_b    <= '0;
              frame_error <= 1'b1;
              busy        <= 1'b0;
            end else begin
              timeout_cnt <= timeout_cnt + TW'(1);
            end
          end
        end

        S_EXEC: begin
          // lat_cnt reaches ALU_LATENCY in the first cycle i_result is valid.
          if (lat_cnt == LAT_LAST) begin
            tx_buf <= {seq, i_carry, (i_result == '0), i_result};
            seq    <= seq + 6'd1;
            tx_idx <= '0;
            state  <= S_SEND;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end

        S_SEND: begin
          if (tx_fire) begin
            tx_buf <= tx_buf >> 8;
            if (tx_idx == TX_LAST) begin
              busy  <= 1'b0;
              state <= S_RECV;
            end else begin
              tx_idx <= tx_idx + TXW'(1);
            end
          end
        end

        default: state <= S_RECV;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_frame_interface.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_frame_interface
// Purpose  : Self-checking bench for alu_frame_interface (16-bit ALU, latency 1,
//            timeout 8). A frame-level model predicts operands, pops, TX bytes,
//            busy and frame-error every cycle; a final table pins the TX stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_frame_interface;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_empty = 1'b1;
  logic        rx_read;
  logic [15:0] op_a, op_b;
  logic [5:0]  opcode;
  logic [15:0] alu_result;
  logic        alu_carry;
  logic        tx_full = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_write;
  logic        frame_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_frame_interface #(
    .DATA_WIDTH(16), .OPCODE_WIDTH(6), .ALU_LATENCY(1), .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clock(clk), .i_reset(rst_n),
    .i_rxff_data(rx_data), .i_rxff_empty(rx_empty), .o_rxff_read(rx_read),
    .o_operandA(op_a), .o_operandB(op_b), .o_opcode(opcode),
    .i_result(alu_result), .i_carry(alu_carry),
    .i_txff_full(tx_full), .o_txff_data(tx_data), .o_txff_write(tx_write),
    .o_frame_error(frame_err), .o_busy(busy)
  );

  // ALU stand-in: an adder; combinational output is valid within one cycle.
  assign {alu_carry, alu_result} = {1'b0, op_a} + {1'b0, op_b};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- RX FIFO model (show-ahead) ----------------
  logic [7:0] rxq[$];

  task automatic rx_refresh();
    rx_empty = (rxq.size() == 0);
    rx_data  = (rxq.size() == 0) ? 8'd0 : rxq[0];
  endtask

  always @(negedge clk) begin
    if (rx_read) begin
      @(posedge clk);
      #1;
      void'(rxq.pop_front());
      rx_refresh();
    end
  end

  // ---------------- Frame-level reference model ----------------
  logic [7:0]  fb[$];
  logic [7:0]  txexp[$];
  logic [7:0]  txlog[$];
  logic [15:0] exp_a = 16'd0, exp_b = 16'd0;
  logic [5:0]  exp_op = 6'd0;
  logic        exp_busy = 1'b0, exp_ferr = 1'b0, in_recv = 1'b1, first_pending = 1'b0;
  int          idle = 0, tx_left = 0, since_op = 0, seq_m = 0;
  int          ferr_count = 0, rd_count = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      fb.delete(); txexp.delete();
      exp_a = 0; exp_b = 0; exp_op = 0; exp_busy = 0; exp_ferr = 0;
      in_recv = 1; first_pending = 0; idle = 0; tx_left = 0; seq_m = 0;
      check("reset_outputs", {rx_read, op_a, op_b, opcode, tx_data, tx_write, frame_err, busy}, 0);
    end else begin
      logic exp_rd;
      since_op++;
      exp_rd = in_recv && !rx_empty;
      check("rx_read", rx_read, exp_rd);
      check("operandA", op_a, exp_a);
      check("operandB", op_b, exp_b);
      check("opcode", opcode, exp_op);
      check("busy", busy, exp_busy);
      check("frame_error", frame_err, exp_ferr);
      if (frame_err) ferr_count++;
      if (rx_read) rd_count++;
      exp_ferr = 0;
      if (tx_write) begin
        check("tx_write_while_full", tx_full, 0);
        check("tx_write_expected", 64'(txexp.size() != 0), 1);
        if (txexp.size() != 0) check("tx_data", tx_data, txexp.pop_front());
        txlog.push_back(tx_data);
        if (first_pending) begin
          check("first_tx_latency", since_op, 3);
          first_pending = 0;
        end
        if (tx_left > 0) begin
          tx_left--;
          if (tx_left == 0) begin
            exp_busy = 0;
            in_recv = 1;
          end
        end
      end
      // Model update for the next cycle.
      if (exp_rd) begin
        fb.push_back(rx_data);
        idle = 0;
        exp_busy = 1;
        if (fb.size() == 5) begin
          logic [16:0] s;
          logic [15:0] a, b;
          a = {fb[1], fb[0]};
          b = {fb[3], fb[2]};
          s = {1'b0, a} + {1'b0, b};
          exp_a = a; exp_b = b; exp_op = fb[4][5:0];
          txexp.push_back(s[7:0]);
          txexp.push_back(s[15:8]);
          txexp.push_back({6'(seq_m), s[16], s[15:0] == 16'd0});
          seq_m = (seq_m + 1) % 64;
          fb.delete();
          in_recv = 0; tx_left = 3; since_op = 0; first_pending = 1;
        end
      end else if (fb.size() > 0 && rx_empty) begin
        idle++;
        if (idle == 8) begin
          fb.delete(); idle = 0; exp_ferr = 1; exp_busy = 0;
        end
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic push(input logic [7:0] b[]);
    @(posedge clk); #2;
    foreach (b[i]) rxq.push_back(b[i]);
    rx_refresh();
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (n < max_cycles && (busy || !rx_empty || txexp.size() != 0)) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", 64'(n >= max_cycles), 0);
  endtask

  task automatic wait_write(input int max_cycles);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_write && n < max_cycles);
    check("wait_write_timeout", 64'(!tx_write), 0);
  endtask

  logic [7:0] gold [0:24] = '{
    8'hAC, 8'h68, 8'h00,   // 0x1234+0x5678, seq0
    8'h00, 8'h01, 8'h04,   // 0x00FF+0x0001, seq1
    8'h00, 8'h00, 8'h0B,   // 0x8000+0x8000 -> zero+carry, seq2
    8'h44, 8'h66, 8'h0C,   // after timeout: 0x2211+0x4433, seq3
    8'h03, 8'h03, 8'h10,   // TX-full stall: 0x0101+0x0202, seq4
    8'h0B,                 // first byte only, reset mid-send
    8'h00, 8'h00, 8'h01,   // after reset: 0+0, seq0
    8'h30, 8'h00, 8'h04,   // queued frame 1, seq1
    8'h00, 8'h00, 8'h0B    // queued frame 2: 0xFFFF+1, seq2
  };

  initial begin
    rx_refresh();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Frame 1: basic addition.
    push('{8'h34, 8'h12, 8'h78, 8'h56, 8'h20});
    wait_idle(40);
    check("f1_operandA", op_a, 16'h1234);
    check("f1_operandB", op_b, 16'h5678);
    check("f1_opcode", opcode, 6'h20);
    check("f1_read_count", rd_count, 5);

    // Frames 2 and 3: third frame produces zero result with carry.
    push('{8'hFF, 8'h00, 8'h01, 8'h00, 8'h21});
    wait_idle(40);
    push('{8'h00, 8'h80, 8'h00, 8'h80, 8'h20});
    wait_idle(40);

    // Timeout: two bytes then silence.
    push('{8'hAA, 8'hBB});
    repeat (14) @(negedge clk);
    check("to_pulse_count", ferr_count, 1);
    check("to_operandA_kept", op_a, 16'h8000);
    push('{8'h11, 8'h22, 8'h33, 8'h44, 8'h05});
    wait_idle(40);
    check("to_next_operandA", op_a, 16'h2211);

    // TX FIFO full for 5 cycles mid-send.
    push('{8'h01, 8'h01, 8'h02, 8'h02, 8'h00});
    wait_write(40);
    @(posedge clk); #2 tx_full = 1'b1;
    repeat (5) @(posedge clk);
    #2 tx_full = 1'b0;
    wait_idle(40);

    // Reset after the first result byte has been written.
    push('{8'h05, 8'h00, 8'h06, 8'h00, 8'h20});
    wait_write(40);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("rst_async_write", tx_write, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_operandA", op_a, 16'h0000);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    push('{8'h00, 8'h00, 8'h00, 8'h00, 8'h3F});
    wait_idle(40);

    // Two frames already waiting in the RX FIFO.
    push('{8'h10, 8'h00, 8'h20, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h02});
    wait_idle(80);

    check("tx_total_bytes", txlog.size(), 25);
    for (int i = 0; i < 25; i++)
      if (i < txlog.size()) check($sformatf("tx_stream[%0d]", i), txlog[i], gold[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/alu_frame_interface.md
Name: alu_frame_interface

Overview:
Next-generation bridge between the UART RX/TX FIFOs and the ALU. It assembles multi-byte operand frames (A, B, opcode) from the 8-bit RX FIFO for an ALU of parametrised width. It then waits a configurable ALU latency and returns the result LSB-first, followed by a status byte, through the TX FIFO. Compared with the previous interface it adds atomic operand update, an inter-byte timeout with frame discard, a status byte and a frame sequence counter.

Parameters:
DATA_WIDTH, 8, ALU operand/result width; must be a multiple of 8 (8..64).
OPCODE_WIDTH, 6, ALU opcode width; taken from the low bits of the opcode byte (1..8).
ALU_LATENCY, 1, cycles from operand update to valid i_result (1..15).
TIMEOUT_CYCLES, 1024, idle cycles allowed between bytes of one frame; 0 disables the timeout.

Ports:
i_clock  in  1  system clock, rising edge.
i_reset  in  1  asynchronous, active-low reset.
i_rxff_data  in  8  RX FIFO head byte (show-ahead: valid whenever i_rxff_empty=0).
i_rxff_empty  in  1  RX FIFO empty.
o_rxff_read  out  1  pop strobe; head byte is consumed in the same cycle.
o_operandA  out  DATA_WIDTH  ALU operand A.
o_operandB  out  DATA_WIDTH  ALU operand B.
o_opcode  out  OPCODE_WIDTH  ALU opcode.
i_result  in  DATA_WIDTH  ALU result.
i_carry  in  1  ALU carry-out.
i_txff_full  in  1  TX FIFO full.
o_txff_data  out  8  byte to TX FIFO.
o_txff_write  out  1  push strobe.
o_frame_error  out  1  one-cycle pulse on timeout discard.
o_busy  out  1  high from first accepted byte until the status byte is pushed.

Behaviour:
- BYTES = DATA_WIDTH/8. A frame is 2*BYTES+1 bytes: A (LSB first), then B (LSB first), then the opcode byte.
- Reset (async assert; release synchronous to i_clock):
  - state=RECV; byte counter, timeout counter and sequence counter = 0.
  - All outputs = 0, including o_operandA/B and o_opcode.
  - Reset mid-frame or mid-send drops everything with no partial TX writes.
- RECV:
  - o_rxff_read = ~i_rxff_empty (combinational; at most one byte per cycle).
  - Each accepted byte goes into a shadow register slot selected by the byte counter; counter increments.
  - On acceptance of the opcode byte (counter = 2*BYTES), the next edge loads o_operandA, o_operandB and o_opcode (opcode = byte[OPCODE_WIDTH-1:0]) from the shadows simultaneously. Go to EXEC and clear the counter.
  - Outputs never show a partially received frame.
- Timeout:
  - Counts cycles in RECV with counter>0 and i_rxff_empty=1; cleared on each accepted byte.
  - When it reaches TIMEOUT_CYCLES: discard the shadows, counter=0, pulse o_frame_error for one cycle, stay in RECV. Operand outputs keep their previous values.
  - With counter=0 the timeout never fires. A byte arriving in the same cycle the count would expire wins, and the timeout is cleared.
- EXEC:
  - Wait exactly ALU_LATENCY cycles, with o_rxff_read=0.
  - Then capture i_result into a TX shift register, and build the status byte {seq[5:0], i_carry, (i_result==0)}.
  - seq = number of completed frames mod 64 before this one. seq increments after capture.
  - Go to SEND.
- SEND:
  - o_txff_data = current byte; o_txff_write = ~i_txff_full. Never write while full.
  - Shift to the next byte on each write. Order: result bytes LSB first, then status byte.
  - After the status write: o_busy falls next cycle, return to RECV.
  - RX bytes are not consumed during EXEC/SEND; they queue in the RX FIFO.
- Latency: opcode accepted at cycle T → operands valid T+1 → first TX write at T+1+ALU_LATENCY+1 at earliest.
- Total TX bytes per frame = BYTES+1, back-to-back when never full.

Test Plan:
- DATA_WIDTH=16, ALU_LATENCY=1: RX 0x34,0x12,0x78,0x56,0x20; ALU returns A+B → operands 0x1234/0x5678 update in one cycle; TX 0xAC,0x68,0x00; o_rxff_read high on 5 cycles.
- Result 0 with i_carry=1 on the third frame → status byte 0x0B (seq=2, carry, zero).
- TIMEOUT_CYCLES=8: send 2 bytes, then idle 8 cycles → o_frame_error single pulse, operands unchanged. Next 5-byte frame is processed normally with no shifted bytes.
- Hold i_txff_full=1 for 5 cycles during SEND → o_txff_write stays 0 during those cycles; byte order is preserved; no byte is lost or duplicated.
- Assert i_reset=0 mid-SEND after 1 byte → all outputs 0 immediately (async); no further writes. Next frame reports seq=0.
- RX FIFO already holding 10 bytes (two frames) → the second frame is not read until the first status byte is pushed; both result sets are correct and in order.
